// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB types, geometry defaults and index/tag/counter helpers.
package branch_target_buffer_pkg;

  localparam int unsigned BTB_ADDR_W = 32;
  localparam int unsigned BTB_DEPTH  = 16;
  localparam int unsigned BTB_CNT_W  = 2;
  localparam int unsigned BTB_IDX_W  = $clog2(BTB_DEPTH);

  // Weakly-taken start value: this constant placed in the counter MSB.
  localparam int unsigned BTB_CNT_INIT = 1;

  typedef struct packed {
    logic                               valid;
    logic [BTB_ADDR_W-BTB_IDX_W-3:0]    tag;
    logic [BTB_ADDR_W-1:0]              target;
    logic [BTB_CNT_W-1:0]               cnt;
  } btb_entry_t;

  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned w);
    int unsigned max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= max_v) ? cnt : cnt + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned cnt, input int unsigned w);
    int unsigned max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (cnt == 32'd0) return 32'd0;
    return (cnt > max_v) ? max_v : cnt - 32'd1;
  endfunction

  // Word-aligned PC: bits [1:0] never participate in index or tag.
  function automatic logic [63:0] btb_idx(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Up/down saturating direction counter with load, one per BTB entry.
module btb_sat_counter
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load (allocation) has priority; otherwise step toward the resolved direction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (inc_i) begin
      cnt_q <= CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end else if (dec_i) begin
      cnt_q <= CNT_W'(sat_dec(32'(cnt_q), CNT_W));
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational IF lookup, ID-stage training.
// Optional performance counters are built when BTB_PERF_CNT_EN is defined.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = BTB_ADDR_W,
  parameter int unsigned DEPTH  = BTB_DEPTH,
  parameter int unsigned CNT_W  = BTB_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_en_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              inv_i
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lookups_o,
  output logic [31:0]       perf_hits_o,
  output logic [31:0]       perf_allocs_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("branch_target_buffer: DEPTH must be a power of two >= 2");
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("branch_target_buffer: CNT_W must be in 1..31");
  end
  if (ADDR_W > 64 || ADDR_W <= IDX_W + 2) begin : g_bad_addr_w
    $error("branch_target_buffer: ADDR_W must leave at least one tag bit and be <= 64");
  end

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [CNT_W-1:0]  cnt      [DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, upd_go, alloc, train_hit;

  assign lk_idx = IDX_W'(btb_idx(64'(pc_i), IDX_W));
  assign lk_tag = TAG_W'(btb_tag(64'(pc_i), IDX_W));
  assign up_idx = IDX_W'(btb_idx(64'(upd_pc_i), IDX_W));
  assign up_tag = TAG_W'(btb_tag(64'(upd_pc_i), IDX_W));

  // Lookup reads only registered state, so a same-cycle update is never bypassed.
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_hit_o    = lk_hit;
  assign pred_taken_o  = lk_hit & cnt[lk_idx][CNT_W-1];
  assign pred_target_o = lk_hit ? target_q[lk_idx] : '0;

  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign upd_go    = upd_valid_i & ~inv_i;
  assign alloc     = upd_go & ~up_hit & upd_taken_i;
  assign train_hit = upd_go & up_hit;

  // Entry valid/tag/target: any taken resolution writes tag and target (alloc or refresh).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (inv_i) begin
      valid_q <= '0;
    end else if (upd_valid_i && upd_taken_i) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_cnt
    logic sel;
    assign sel = (up_idx == IDX_W'(i));

    btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (alloc & sel),
      .load_val_i (CNT_W'(BTB_CNT_INIT << (CNT_W - 1))),
      .inc_i      (train_hit & upd_taken_i & sel),
      .dec_i      (train_hit & ~upd_taken_i & sel),
      .cnt_o      (cnt[i])
    );
  end

`ifdef BTB_PERF_CNT_EN
  // Free-running wrap-around event counters; only reset clears them, not inv_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_lookups_o <= '0;
      perf_hits_o    <= '0;
      perf_allocs_o  <= '0;
    end else begin
      if (lookup_en_i)          perf_lookups_o <= perf_lookups_o + 32'd1;
      if (lookup_en_i & lk_hit) perf_hits_o    <= perf_hits_o + 32'd1;
      if (alloc)                perf_allocs_o  <= perf_allocs_o + 32'd1;
    end
  end
`else
  logic unused_lookup_en;
  assign unused_lookup_en = lookup_en_i;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (default geometry).
module tb_branch_target_buffer;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } pred_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lookup_en_i;
  logic [31:0] pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        inv_i;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_lookups_o, perf_hits_o, perf_allocs_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pred_t exp_q[$];
  pred_t act_q[$];
  string name_q[$];

  branch_target_buffer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lookup_en_i   (lookup_en_i),
    .pc_i          (pc_i),
    .pred_hit_o    (pred_hit_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .inv_i         (inv_i)
`ifdef BTB_PERF_CNT_EN
    ,
    .perf_lookups_o(perf_lookups_o),
    .perf_hits_o   (perf_hits_o),
    .perf_allocs_o (perf_allocs_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // One training pulse, applied at the posedge between two negedges.
  task automatic tick(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk_i);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    upd_target_i = tgt;
    @(negedge clk_i);
    upd_valid_i  = 1'b0;
  endtask

  // Drive a lookup PC, push the expected prediction and the sampled one.
  task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                      input logic [31:0] etg, input string nm);
    @(negedge clk_i);
    pc_i = pc;
    exp_q.push_back(pred_t'{eh, et, etg});
    name_q.push_back(nm);
    #2;
    act_q.push_back(pred_t'{pred_hit_o, pred_taken_o, pred_target_o});
  endtask

  task automatic test_reset;
    pred_t e, a;
    string nm;
    // Power-on reset state while rst_i is held high.
    pc_i = 32'h10;
    exp_q.push_back(pred_t'{1'b0, 1'b0, 32'h0});
    name_q.push_back("reset_hold");
    #1;
    act_q.push_back(pred_t'{pred_hit_o, pred_taken_o, pred_target_o});
    @(negedge clk_i);
    rst_i = 1'b0;
    look(32'h10, 1'b0, 1'b0, 32'h0, "post_reset_empty");
    // Train 0x10, then reset mid-cycle while another update is pending.
    tick(32'h10, 1'b1, 32'h abc0);
    look(32'h10, 1'b1, 1'b1, 32'habc0, "trained_0x10");
    @(negedge clk_i);
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h10;
    upd_taken_i  = 1'b1;
    upd_target_i = 32'h1234;
    #2 rst_i = 1'b1;
    #1;
    exp_q.push_back(pred_t'{1'b0, 1'b0, 32'h0});
    name_q.push_back("reset_async");
    act_q.push_back(pred_t'{pred_hit_o, pred_taken_o, pred_target_o});
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    rst_i       = 1'b0;
    look(32'h10, 1'b0, 1'b0, 32'h0, "reset_released");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                 nm, a.hit, a.taken, a.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_allocate;
    pred_t e, a;
    string nm;
    tick(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b1, 32'h100, "alloc_0x40");
    tick(32'h44, 1'b0, 32'h777);
    look(32'h44, 1'b0, 1'b0, 32'h0, "nt_miss_0x44");
    look(32'h40, 1'b1, 1'b1, 32'h100, "alloc_0x40_kept");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                 nm, a.hit, a.taken, a.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_saturation;
    pred_t e, a;
    string nm;
    // From weakly taken (2): three taken updates must stick at 3.
    for (int i = 0; i < 3; i++) tick(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b1, 32'h100, "sat_hi_3");
    tick(32'h40, 1'b0, 32'h999);
    look(32'h40, 1'b1, 1'b1, 32'h100, "sat_dec_2");
    tick(32'h40, 1'b0, 32'h999);
    look(32'h40, 1'b1, 1'b0, 32'h100, "sat_dec_1");
    for (int i = 0; i < 5; i++) begin
      tick(32'h40, 1'b0, 32'h999);
      look(32'h40, 1'b1, 1'b0, 32'h100, $sformatf("sat_lo_%0d", i));
    end
    tick(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b0, 32'h100, "sat_lo_inc_1");
    tick(32'h40, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b1, 32'h100, "sat_lo_inc_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                 nm, a.hit, a.taken, a.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_alias;
    pred_t e, a;
    string nm;
    tick(32'h80, 1'b1, 32'h300);
    look(32'h40, 1'b0, 1'b0, 32'h0, "alias_old_miss");
    look(32'h80, 1'b1, 1'b1, 32'h300, "alias_new_hit");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                 nm, a.hit, a.taken, a.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

  task automatic test_collision_inv;
    pred_t e, a;
    string nm;
    tick(32'h40, 1'b1, 32'h100);
    @(negedge clk_i);
    pc_i         = 32'h40;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h40;
    upd_taken_i  = 1'b1;
    upd_target_i = 32'h200;
    exp_q.push_back(pred_t'{1'b1, 1'b1, 32'h100});
    name_q.push_back("collide_same_cycle");
    #2 act_q.push_back(pred_t'{pred_hit_o, pred_taken_o, pred_target_o});
    @(negedge clk_i);
    upd_valid_i = 1'b0;
    exp_q.push_back(pred_t'{1'b1, 1'b1, 32'h200});
    name_q.push_back("collide_next_cycle");
    #2 act_q.push_back(pred_t'{pred_hit_o, pred_taken_o, pred_target_o});
    // Invalidate together with an allocating update: invalidate wins.
    @(negedge clk_i);
    inv_i        = 1'b1;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h44;
    upd_taken_i  = 1'b1;
    upd_target_i = 32'h500;
    @(negedge clk_i);
    inv_i       = 1'b0;
    upd_valid_i = 1'b0;
    look(32'h40, 1'b0, 1'b0, 32'h0, "inv_0x40");
    look(32'h44, 1'b0, 1'b0, 32'h0, "inv_0x44");
    look(32'h80, 1'b0, 1'b0, 32'h0, "inv_0x80");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                 nm, a.hit, a.taken, a.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask

`ifdef BTB_PERF_CNT_EN
  task automatic test_perf;
    pred_t e, a;
    string nm;
    logic [31:0] pcs [10];
    logic        hits[10];
    logic [31:0] tgts[10];
    pcs  = '{32'h40, 32'h44, 32'h48, 32'h4c, 32'h40, 32'h80, 32'h48, 32'h88, 32'h0, 32'h50};
    hits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tgts = '{32'h100, 32'h0, 32'h180, 32'h0, 32'h100, 32'h0, 32'h180, 32'h0, 32'h0, 32'h0};
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    tick(32'h40, 1'b1, 32'h100);
    tick(32'h48, 1'b1, 32'h180);
    tick(32'h40, 1'b1, 32'h100);
    tick(32'h4c, 1'b0, 32'h0);
    @(posedge clk_i);
    #1 lookup_en_i = 1'b1;
    for (int i = 0; i < 10; i++)
      look(pcs[i], hits[i], hits[i], tgts[i], $sformatf("perf_look_%0d", i));
    @(negedge clk_i);
    lookup_en_i = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (perf_lookups_o !== 32'd10) begin
        n_fail++;
        $display("FAIL perf_lookups_%0d: got %0d want 10", k, perf_lookups_o);
      end
      n_checks++;
      if (perf_hits_o !== 32'd4) begin
        n_fail++;
        $display("FAIL perf_hits_%0d: got %0d want 4", k, perf_hits_o);
      end
      n_checks++;
      if (perf_allocs_o !== 32'd2) begin
        n_fail++;
        $display("FAIL perf_allocs_%0d: got %0d want 2", k, perf_allocs_o);
      end
      if (k == 0) begin
        @(negedge clk_i);
        inv_i = 1'b1;
        @(negedge clk_i);
        inv_i = 1'b0;
        #2;
      end
    end
    look(32'h40, 1'b0, 1'b0, 32'h0, "perf_inv_miss");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                 nm, a.hit, a.taken, a.tgt, e.hit, e.taken, e.tgt);
      end
    end
  endtask
`endif

  initial begin
    rst_i        = 1'b1;
    lookup_en_i  = 1'b0;
    pc_i         = 32'h0;
    upd_valid_i  = 1'b0;
    upd_pc_i     = 32'h0;
    upd_taken_i  = 1'b0;
    upd_target_i = 32'h0;
    inv_i        = 1'b0;
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_collision_inv();
`ifdef BTB_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
